// File: rtl/atm_account_core_pkg.sv
// Shared definitions for the ATM account core: command and status encodings,
// boolean constants and the default table sizing/reset values.
package atm_account_core_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int          DEF_NUM_ACCOUNTS = 10;
  localparam logic [31:0] DEF_INIT_BALANCE = 32'd500;
  localparam logic [15:0] DEF_PIN_BASE     = 16'd1000;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_BALANCE    = 3'd1,
    OP_WITHDRAW   = 3'd2,
    OP_DEPOSIT    = 3'd3,
    OP_CHANGE_PIN = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_OK                 = 2'd0,
    ST_AUTH_FAIL          = 2'd1,
    ST_INSUFFICIENT       = 2'd2,
    ST_BAD_OP_OR_OVERFLOW = 2'd3
  } status_e;

endpackage

// File: rtl/atm_pin_checker.sv
// Combinational account lookup: range-checks the account number and compares
// the entered PIN against the stored PIN of that account.
module atm_pin_checker
  import atm_account_core_pkg::*;
#(
  parameter int NUM_ACCOUNTS = DEF_NUM_ACCOUNTS
) (
  input  logic [3:0]  i_acc_num,
  input  logic [15:0] i_pin,
  input  logic [15:0] i_pin_table [NUM_ACCOUNTS],
  output logic [3:0]  o_acc_index,
  output logic        o_acc_found,
  output logic        o_acc_auth
);

  logic w_found;
  logic [3:0] w_index;

  // Out-of-range accounts map to index 0 so the table read never goes out of bounds.
  always_comb begin
    w_found = (32'(i_acc_num) < NUM_ACCOUNTS);
    w_index = w_found ? i_acc_num : 4'd0;
  end

  assign o_acc_index = w_index;
  assign o_acc_found = w_found;
  assign o_acc_auth  = w_found && (i_pin == i_pin_table[w_index]);

endmodule

// File: rtl/atm_account_core.sv
// ATM account core: holds the balance and PIN tables and executes one
// authenticated command per accepted strobe, reporting the result a cycle later.
module atm_account_core
  import atm_account_core_pkg::*;
#(
  parameter int          NUM_ACCOUNTS = DEF_NUM_ACCOUNTS,
  parameter logic [31:0] INIT_BALANCE = DEF_INIT_BALANCE,
  parameter logic [15:0] PIN_BASE     = DEF_PIN_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_acc_num,
  input  logic [15:0] i_pin,
  input  logic [15:0] i_new_pin,
  input  logic [31:0] i_amount,
  input  logic [2:0]  i_op,
  input  logic        i_op_valid,
  output logic [3:0]  o_acc_index,
  output logic        o_acc_found,
  output logic        o_acc_auth,
  output logic        o_op_done,
  output logic        o_op_ok,
  output logic [1:0]  o_status,
  output logic [31:0] o_balance
);

  logic [31:0] r_balance_table [NUM_ACCOUNTS];
  logic [15:0] r_pin_table     [NUM_ACCOUNTS];
  logic        r_op_done;
  logic        r_op_ok;
  status_e     r_status;
  logic [31:0] r_balance;

  logic [3:0]  w_idx;
  logic        w_found;
  logic        w_auth;
  logic        w_accept;
  logic [31:0] w_cur_bal;
  logic [32:0] w_sum;
  logic        w_ok;
  status_e     w_status;
  logic [31:0] w_bal_out;
  logic        w_wr_bal;
  logic [31:0] w_new_bal;
  logic        w_wr_pin;

  atm_pin_checker #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS)
  ) u_pin_checker (
    .i_acc_num   (i_acc_num),
    .i_pin       (i_pin),
    .i_pin_table (r_pin_table),
    .o_acc_index (w_idx),
    .o_acc_found (w_found),
    .o_acc_auth  (w_auth)
  );

  assign w_accept  = i_op_valid && (i_op != OP_NOP);
  assign w_cur_bal = r_balance_table[w_idx];
  assign w_sum     = {1'b0, w_cur_bal} + {1'b0, i_amount};

  // Command decode: decides the result and which table (if any) is written.
  always_comb begin
    w_ok      = FALSE;
    w_status  = ST_OK;
    w_bal_out = 32'd0;
    w_wr_bal  = FALSE;
    w_new_bal = w_cur_bal;
    w_wr_pin  = FALSE;
    if (!w_auth) begin
      w_status = ST_AUTH_FAIL;
    end else begin
      w_bal_out = w_cur_bal;
      case (op_e'(i_op))
        OP_BALANCE: w_ok = TRUE;
        OP_WITHDRAW: begin
          if (i_amount <= w_cur_bal) begin
            w_ok      = TRUE;
            w_wr_bal  = TRUE;
            w_new_bal = w_cur_bal - i_amount;
            w_bal_out = w_new_bal;
          end else begin
            w_status = ST_INSUFFICIENT;
          end
        end
        OP_DEPOSIT: begin
          if (!w_sum[32]) begin
            w_ok      = TRUE;
            w_wr_bal  = TRUE;
            w_new_bal = w_sum[31:0];
            w_bal_out = w_new_bal;
          end else begin
            w_status = ST_BAD_OP_OR_OVERFLOW;
          end
        end
        OP_CHANGE_PIN: begin
          w_ok     = TRUE;
          w_wr_pin = TRUE;
        end
        default: w_status = ST_BAD_OP_OR_OVERFLOW;
      endcase
    end
  end

  // Table state: reverts to reset contents, otherwise updated by accepted commands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_balance_table[i] <= INIT_BALANCE;
        r_pin_table[i]     <= PIN_BASE + 16'(i);
      end
    end else if (w_accept) begin
      if (w_wr_bal) r_balance_table[w_idx] <= w_new_bal;
      if (w_wr_pin) r_pin_table[w_idx]     <= i_new_pin;
    end
  end

  // Result registers: op_done pulses per accepted command, the rest hold until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_done <= FALSE;
      r_op_ok   <= FALSE;
      r_status  <= ST_OK;
      r_balance <= 32'd0;
    end else begin
      r_op_done <= w_accept;
      if (w_accept) begin
        r_op_ok   <= w_ok;
        r_status  <= w_status;
        r_balance <= w_bal_out;
      end
    end
  end

  assign o_acc_index = w_idx;
  assign o_acc_found = w_found;
  assign o_acc_auth  = w_auth;
  assign o_op_done   = r_op_done;
  assign o_op_ok     = r_op_ok;
  assign o_status    = r_status;
  assign o_balance   = r_balance;

endmodule

// File: tb/tb_atm_account_core.sv
// Scoreboard bench for atm_account_core: stimulus pushes expected results,
// a monitor pops and compares whenever op_done is seen.
module tb_atm_account_core;

  logic        clk;
  logic        rst;
  logic [3:0]  i_acc_num;
  logic [15:0] i_pin;
  logic [15:0] i_new_pin;
  logic [31:0] i_amount;
  logic [2:0]  i_op;
  logic        i_op_valid;
  logic [3:0]  o_acc_index;
  logic        o_acc_found;
  logic        o_acc_auth;
  logic        o_op_done;
  logic        o_op_ok;
  logic [1:0]  o_status;
  logic [31:0] o_balance;

  typedef struct {
    string       name;
    logic        ok;
    logic [1:0]  status;
    logic [31:0] balance;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  atm_account_core dut (
    .clk        (clk),
    .rst        (rst),
    .i_acc_num  (i_acc_num),
    .i_pin      (i_pin),
    .i_new_pin  (i_new_pin),
    .i_amount   (i_amount),
    .i_op       (i_op),
    .i_op_valid (i_op_valid),
    .o_acc_index(o_acc_index),
    .o_acc_found(o_acc_found),
    .o_acc_auth (o_acc_auth),
    .o_op_done  (o_op_done),
    .o_op_ok    (o_op_ok),
    .o_status   (o_status),
    .o_balance  (o_balance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every op_done must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && o_op_done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_op_done: got op_done=1, required no result pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_op_ok !== e.ok || o_status !== e.status || o_balance !== e.balance) begin
          n_err++;
          $display("FAIL %s: got ok=%0b status=%0d balance=%0d, required ok=%0b status=%0d balance=%0d",
                   e.name, o_op_ok, o_status, o_balance, e.ok, e.status, e.balance);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic lookup(input logic [3:0] acc, input logic [15:0] p);
    @(negedge clk);
    i_op_valid = 1'b0;
    i_acc_num  = acc;
    i_pin      = p;
    #1;
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [3:0] acc,
                       input logic [15:0] p, input logic [31:0] amt, input logic [15:0] npin,
                       input logic eok, input logic [1:0] est, input logic [31:0] ebal);
    exp_t e;
    @(negedge clk);
    i_op       = op;
    i_acc_num  = acc;
    i_pin      = p;
    i_amount   = amt;
    i_new_pin  = npin;
    i_op_valid = 1'b1;
    e.name = name; e.ok = eok; e.status = est; e.balance = ebal;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    i_op_valid = 1'b0;
    i_op       = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    i_acc_num = 4'd0; i_pin = 16'd0; i_new_pin = 16'd0;
    i_amount = 32'd0; i_op = 3'd0; i_op_valid = 1'b0;
    do_reset();
    #1;
    check("reset_op_done", 32'(o_op_done), 32'd0);
    check("reset_op_ok",   32'(o_op_ok), 32'd0);
    check("reset_status",  32'(o_status), 32'd0);
    check("reset_balance", o_balance, 32'd0);

    lookup(4'd3, 16'd1003);
    check("acc3_found", 32'(o_acc_found), 32'd1);
    check("acc3_auth",  32'(o_acc_auth), 32'd1);
    check("acc3_index", 32'(o_acc_index), 32'd3);
    lookup(4'd3, 16'd1004);
    check("acc3_badpin_auth", 32'(o_acc_auth), 32'd0);
    lookup(4'd12, 16'd1012);
    check("acc12_found", 32'(o_acc_found), 32'd0);
    check("acc12_index", 32'(o_acc_index), 32'd0);
    check("acc12_auth",  32'(o_acc_auth), 32'd0);

    issue("acc2_balance",  3'd1, 4'd2, 16'd1002, 32'd0,   16'd0, 1'b1, 2'd0, 32'd500); idle();
    issue("acc2_wd200",    3'd2, 4'd2, 16'd1002, 32'd200, 16'd0, 1'b1, 2'd0, 32'd300); idle();
    issue("acc2_dep50",    3'd3, 4'd2, 16'd1002, 32'd50,  16'd0, 1'b1, 2'd0, 32'd350); idle();

    // NOP strobe must not produce op_done; the monitor flags any stray pulse.
    issue("nop_dummy", 3'd0, 4'd2, 16'd1002, 32'd0, 16'd0, 1'b0, 2'd0, 32'd0);
    void'(exp_q.pop_back());
    idle();

    issue("acc5_wd501",    3'd2, 4'd5, 16'd1005, 32'd501, 16'd0, 1'b0, 2'd2, 32'd500); idle();
    issue("acc5_wd500",    3'd2, 4'd5, 16'd1005, 32'd500, 16'd0, 1'b1, 2'd0, 32'd0);   idle();
    issue("acc5_wd0",      3'd2, 4'd5, 16'd1005, 32'd0,   16'd0, 1'b1, 2'd0, 32'd0);   idle();

    issue("acc0_chpin",    3'd4, 4'd0, 16'd1000, 32'd0, 16'd4321, 1'b1, 2'd0, 32'd500); idle();
    lookup(4'd0, 16'd1000);
    check("acc0_oldpin_auth", 32'(o_acc_auth), 32'd0);
    lookup(4'd0, 16'd4321);
    check("acc0_newpin_auth", 32'(o_acc_auth), 32'd1);
    do_reset();
    lookup(4'd0, 16'd1000);
    check("acc0_pin_after_reset", 32'(o_acc_auth), 32'd1);

    issue("acc7_badpin_wd", 3'd2, 4'd7, 16'd9999, 32'd100, 16'd0, 1'b0, 2'd1, 32'd0);  idle();
    issue("acc7_balance",   3'd1, 4'd7, 16'd1007, 32'd0,   16'd0, 1'b1, 2'd0, 32'd500); idle();

    issue("acc1_dep_ovf",  3'd3, 4'd1, 16'd1001, 32'hFFFF_FFFF, 16'd0, 1'b0, 2'd3, 32'd500); idle();
    issue("acc1_illegal6", 3'd6, 4'd1, 16'd1001, 32'd0, 16'd0, 1'b0, 2'd3, 32'd500);
    issue("acc1_dep10",    3'd3, 4'd1, 16'd1001, 32'd10,  16'd0, 1'b1, 2'd0, 32'd510);
    issue("acc1_wd510",    3'd2, 4'd1, 16'd1001, 32'd510, 16'd0, 1'b1, 2'd0, 32'd0);
    idle();
    idle();

    // Reset right after an accepted strobe drops the result and reverts the table.
    @(negedge clk);
    i_op = 3'd2; i_acc_num = 4'd3; i_pin = 16'd1003; i_amount = 32'd100; i_op_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_op_valid = 1'b0;
    #1;
    check("reset_clears_op_done", 32'(o_op_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue("acc3_after_reset", 3'd1, 4'd3, 16'd1003, 32'd0, 16'd0, 1'b1, 2'd0, 32'd500); idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pending_results: got %0d results never reported, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/atm_account_core.md
Name: atm_account_core

Overview:
Account datastore and transaction engine for the ATM controller. It combinationally authenticates an (account number, PIN) pair against an internal PIN table. It executes balance, withdraw, deposit and change-PIN commands against internal balance and PIN tables. It sits under the ATM menu FSM, which issues one command per cycle.

Parameters:
NUM_ACCOUNTS, 10, number of accounts; valid account numbers are 0..NUM_ACCOUNTS-1.
INIT_BALANCE, 32'd500, balance of every account after reset.
PIN_BASE, 16'd1000, reset PIN of account i is PIN_BASE+i.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low.
acc_num  in  4  account number presented by the card.
pin  in  16  entered PIN.
new_pin  in  16  replacement PIN for CHANGE_PIN.
amount  in  32  unsigned transaction amount.
op  in  3  command: 0 NOP, 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN; 5-7 are illegal.
op_valid  in  1  command strobe, sampled on the rising edge.
acc_index  out  4  combinational: acc_num when found, else 0.
acc_found  out  1  combinational: acc_num < NUM_ACCOUNTS.
acc_auth  out  1  combinational: acc_found && pin == pin_table[acc_num].
op_done  out  1  registered one-cycle pulse, asserted the cycle after an accepted strobe.
op_ok  out  1  registered; 1 = the command succeeded.
status  out  2  registered: 0 OK, 1 AUTH_FAIL, 2 INSUFFICIENT, 3 BAD_OP_OR_OVERFLOW.
balance  out  32  registered: balance of the addressed account after the command.

Behaviour:
- Reset, asynchronous on rst low:
  - balance_table[i] = INIT_BALANCE and pin_table[i] = PIN_BASE+i.
  - op_done=0, op_ok=0, status=0, balance=0.
- Authentication is purely combinational from acc_num, pin and the current pin_table; it has no latency.
- Command accepted on a rising edge with op_valid=1 and op != NOP. Results appear on the next cycle: op_done=1 for exactly one cycle, plus op_ok, status and balance.
- op_valid=0, or op=NOP: no state change, op_done=0. op_ok, status and balance hold their last values.
- Authentication is evaluated at the accepting edge. If acc_auth=0: no state change, op_ok=0, status=AUTH_FAIL, balance=0.
- BALANCE: no change; balance=balance_table[idx], op_ok=1.
- WITHDRAW:
  - amount <= balance_table[idx]: subtract amount, op_ok=1. Equality is allowed, leaving 0.
  - Otherwise: no change, op_ok=0, status=INSUFFICIENT.
  - amount=0 succeeds with no change.
- DEPOSIT:
  - 33-bit sum without carry-out: store the sum, op_ok=1.
  - Carry-out: no change, op_ok=0, status=BAD_OP_OR_OVERFLOW.
- CHANGE_PIN: pin_table[idx]=new_pin, op_ok=1, balance=current balance. From the next cycle the old PIN fails acc_auth. new_pin equal to the old PIN is allowed.
- Illegal op (5-7) while authenticated: no change, op_ok=0, status=BAD_OP_OR_OVERFLOW.
- Each strobe touches exactly one account. Back-to-back strobes on consecutive cycles are each processed, and each sees the previous update.
- Reset during or right after a strobe: tables revert and op_done is cleared, with no pending result.
- All arithmetic is unsigned 32-bit; no negative balances.

Decomposition:
- Shared package/defines file:
  - op codes NOP, BALANCE, WITHDRAW, DEPOSIT, CHANGE_PIN.
  - status codes OK, AUTH_FAIL, INSUFFICIENT, BAD_OP_OR_OVERFLOW.
  - TRUE/FALSE.
- Sub-module atm_pin_checker: combinational lookup of acc_num and pin against the PIN table, producing acc_index, acc_found and acc_auth.
- The transaction datapath and both tables live in the top.

Test Plan:
- Reset, then acc_num=3, pin=1003 -> acc_found=1, acc_auth=1, acc_index=3. pin=1004 -> acc_auth=0. acc_num=12 -> acc_found=0, acc_index=0.
- acc 2 (pin 1002): BALANCE -> op_done pulse, balance=500, op_ok=1. WITHDRAW 200 -> balance=300. DEPOSIT 50 -> balance=350.
- acc 5: WITHDRAW 501 -> op_ok=0, status=2, balance stays 500. WITHDRAW 500 -> op_ok=1, balance=0.
- acc 0: CHANGE_PIN new_pin=4321 -> op_ok=1. Next cycle pin=1000 -> acc_auth=0; pin=4321 -> acc_auth=1. Assert rst -> pin 1000 authenticates again.
- Wrong PIN with WITHDRAW 100 on acc 7 -> status=1, op_ok=0; a subsequent BALANCE with the correct PIN shows 500.
- DEPOSIT 32'hFFFFFFFF on acc 1 -> status=3, balance unchanged at 500. op=6 while authenticated -> status=3. Strobes on consecutive cycles, DEPOSIT 10 then WITHDRAW 510 -> both succeed, final balance 0.
